// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, ALUOp codes, opcodes,
// datapath mux selects and the control word decoded from the current state.
package controle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'h0,
    DECODE   = 4'h1,
    EXEC_R   = 4'h2,
    EXEC_I   = 4'h3,
    ALU_WB   = 4'h4,
    MEM_ADDR = 4'h5,
    MEM_RD   = 4'h6,
    MEM_WR   = 4'h7,
    MEM_WB   = 4'h8,
    BRANCH   = 4'h9,
    JUMP     = 4'hA,
    TRAP     = 4'hF
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_LW,
    CLS_SW,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ITYPE,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_BEQ   = 4'b0001;
  localparam logic [3:0] ALUOP_BNE   = 4'b0010;
  localparam logic [3:0] ALUOP_SLTI  = 4'b0011;
  localparam logic [3:0] ALUOP_SLTIU = 4'b0100;
  localparam logic [3:0] ALUOP_ANDI  = 4'b0101;
  localparam logic [3:0] ALUOP_ORI   = 4'b0110;
  localparam logic [3:0] ALUOP_XORI  = 4'b0111;
  localparam logic [3:0] ALUOP_LUI   = 4'b1000;
  localparam logic [3:0] ALUOP_RTYPE = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       illegal;
  } ctrl_t;

  // Every state starts from this word and raises only what it needs.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c           = '0;
    c.alu_op    = ALUOP_ADD;
    c.alu_src_b = SRCB_REGB;
    c.pc_source = PCSRC_ALU;
    return c;
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Controller <-> datapath/memory bundle: opcode and status flags in, control word out.
interface controle_multiciclo_if;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] pc_source;
  logic       pc_en;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_source, pc_en, illegal, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_source, pc_en, illegal, state_dbg
  );

endinterface

// File: rtl/controle_multiciclo_decod_opcode_ula.sv
// Combinational opcode classifier: instruction class for the DECODE dispatch and the ALUOp
// used by immediate-type instructions in EXEC_I.
module decod_opcode_ula
  import controle_pkg::*;
(
  input  logic [5:0] i_op,
  output op_class_t  o_class,
  output logic [3:0] o_alu_op
);

  always_comb begin
    o_class  = CLS_ILLEGAL;
    o_alu_op = ALUOP_ADD;
    case (i_op)
      OP_RTYPE: o_class = CLS_RTYPE;
      OP_LW:    o_class = CLS_LW;
      OP_SW:    o_class = CLS_SW;
      OP_BEQ,
      OP_BNE:   o_class = CLS_BRANCH;
      OP_J:     o_class = CLS_JUMP;
      OP_ADDI:  begin o_class = CLS_ITYPE; o_alu_op = ALUOP_ADD;   end
      OP_SLTI:  begin o_class = CLS_ITYPE; o_alu_op = ALUOP_SLTI;  end
      OP_SLTIU: begin o_class = CLS_ITYPE; o_alu_op = ALUOP_SLTIU; end
      OP_ANDI:  begin o_class = CLS_ITYPE; o_alu_op = ALUOP_ANDI;  end
      OP_ORI:   begin o_class = CLS_ITYPE; o_alu_op = ALUOP_ORI;   end
      OP_XORI:  begin o_class = CLS_ITYPE; o_alu_op = ALUOP_XORI;  end
      OP_LUI:   begin o_class = CLS_ITYPE; o_alu_op = ALUOP_LUI;   end
      default:  o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore controller for the multi-cycle core: R/I 4 cycles, lw 5, sw 4, branch/jump 3, plus one
// per mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR. Optional CTRL_PERF_EN adds cycle/instr counters.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  controle_multiciclo_if.master bus
`ifdef CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_cycles,
  output logic [PERF_W-1:0]     perf_instrs
`endif
);

  state_t     r_state;
  logic [5:0] r_op_q;
  op_class_t  w_class;
  logic [3:0] w_itype_alu_op;
  logic       w_is_bne;
  ctrl_t      w_ctrl;

  decod_opcode_ula u_decod (
    .i_op     (r_op_q),
    .o_class  (w_class),
    .o_alu_op (w_itype_alu_op)
  );

  assign w_is_bne = (r_op_q == OP_BNE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
      r_op_q  <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.mem_ready) begin
            r_state <= DECODE;
            r_op_q  <= bus.opcode;
          end
        end
        DECODE: begin
          case (w_class)
            CLS_RTYPE:  r_state <= EXEC_R;
            CLS_LW,
            CLS_SW:     r_state <= MEM_ADDR;
            CLS_BRANCH: r_state <= BRANCH;
            CLS_JUMP:   r_state <= JUMP;
            CLS_ITYPE:  r_state <= EXEC_I;
            default:    r_state <= TRAP;
          endcase
        end
        EXEC_R,
        EXEC_I:   r_state <= ALU_WB;
        MEM_ADDR: r_state <= (w_class == CLS_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (bus.mem_ready) r_state <= MEM_WB;
        MEM_WR:   if (bus.mem_ready) r_state <= FETCH;
        ALU_WB,
        MEM_WB,
        BRANCH,
        JUMP:     r_state <= FETCH;
        TRAP:     r_state <= TRAP;
        default:  r_state <= TRAP;
      endcase
    end
  end

  always_comb begin
    w_ctrl = ctrl_idle();
    case (r_state)
      FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.ir_write  = bus.mem_ready;
        w_ctrl.pc_en     = bus.mem_ready;
      end
      DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REGB;
        w_ctrl.alu_op    = ALUOP_RTYPE;
      end
      EXEC_I: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = w_itype_alu_op;
      end
      ALU_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = (r_op_q == OP_RTYPE);
      end
      MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REGB;
        w_ctrl.alu_op    = w_is_bne ? ALUOP_BNE : ALUOP_BEQ;
        w_ctrl.pc_source = PCSRC_ALUOUT;
        w_ctrl.pc_en     = w_is_bne ? ~bus.zero : bus.zero;
      end
      JUMP: begin
        w_ctrl.pc_source = PCSRC_JUMP;
        w_ctrl.pc_en     = 1'b1;
      end
      TRAP: begin
        w_ctrl.illegal = 1'b1;
      end
      default: w_ctrl = ctrl_idle();
    endcase
  end

  assign bus.alu_op     = w_ctrl.alu_op;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.i_or_d     = w_ctrl.i_or_d;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.pc_source  = w_ctrl.pc_source;
  assign bus.illegal    = w_ctrl.illegal;
  assign bus.state_dbg  = r_state;

  // Reset parks the FSM in FETCH, whose word requests a read; mask the strobes so nothing
  // reaches memory, IR, PC or the register file while reset_n is low.
  assign bus.mem_read   = w_ctrl.mem_read  & reset_n;
  assign bus.mem_write  = w_ctrl.mem_write & reset_n;
  assign bus.ir_write   = w_ctrl.ir_write  & reset_n;
  assign bus.reg_write  = w_ctrl.reg_write & reset_n;
  assign bus.pc_en      = w_ctrl.pc_en     & reset_n;

`ifdef CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic              w_to_fetch;
  logic [PERF_W-1:0] r_perf_cycles;
  logic [PERF_W-1:0] r_perf_instrs;

  always_comb begin
    w_to_fetch = 1'b0;
    case (r_state)
      ALU_WB, MEM_WB, BRANCH, JUMP: w_to_fetch = 1'b1;
      MEM_WR:                       w_to_fetch = bus.mem_ready;
      default:                      w_to_fetch = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_cycles <= '0;
      r_perf_instrs <= '0;
    end else begin
      if (r_state != TRAP) r_perf_cycles <= r_perf_cycles + PERF_ONE;
      if (w_to_fetch)      r_perf_instrs <= r_perf_instrs + PERF_ONE;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_instrs = r_perf_instrs;
`else
  // Counter width is meaningless without the counters; keep the parameter elaborated.
  if (PERF_W < 1) begin : g_perf_w_unused
  end
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized instruction stream against an instruction-level model; expected control words
// are queued per cycle and compared by an independent negedge monitor.
module tb_controle_multiciclo;
  import controle_pkg::*;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5, C_J = 6, C_ILL = 7;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] aop;
    logic       a;
    logic [1:0] b;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic [1:0] pcs;
    logic       pce;
    logic       ill;
  } ctl_t;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  int         checks  = 0;
  int         errors  = 0;
  ctl_t       exp_q[$];
  string      name_q[$];
  logic [5:0] legal [13];

  always #5 clock = ~clock;

  controle_multiciclo_if bus ();

`ifdef CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_instrs;
  int          model_cycles = 0;
  int          model_instrs = 0;
`endif

  controle_multiciclo #(.PERF_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_instrs (perf_instrs)
`endif
  );

  function automatic logic rbit();
    logic [31:0] r;
    r = $urandom();
    return r[0];
  endfunction

  function automatic logic [5:0] rop();
    logic [31:0] r;
    r = $urandom();
    return r[5:0];
  endfunction

  function automatic int cls(input logic [5:0] op);
    case (op)
      6'b000000: return C_R;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b001000, 6'b001010, 6'b001011, 6'b001100,
      6'b001101, 6'b001110, 6'b001111: return C_I;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] ialu(input logic [5:0] op);
    case (op)
      6'b001000: return 4'b0000;
      6'b001010: return 4'b0011;
      6'b001011: return 4'b0100;
      6'b001100: return 4'b0101;
      6'b001101: return 4'b0110;
      6'b001110: return 4'b0111;
      6'b001111: return 4'b1000;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic ctl_t mk(input logic [3:0] st, input logic [3:0] aop, input logic a,
                              input logic [1:0] b, input logic iord, mr, mw, irw, rw, rd, m2r,
                              input logic [1:0] pcs, input logic pce, ill);
    ctl_t c;
    c.st = st; c.aop = aop; c.a = a; c.b = b; c.iord = iord; c.mr = mr; c.mw = mw;
    c.irw = irw; c.rw = rw; c.rd = rd; c.m2r = m2r; c.pcs = pcs; c.pce = pce; c.ill = ill;
    return c;
  endfunction

  function automatic ctl_t sample();
    return mk(bus.state_dbg, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.i_or_d,
              bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst,
              bus.mem_to_reg, bus.pc_source, bus.pc_en, bus.illegal);
  endfunction

  always @(negedge clock) begin
    ctl_t  e;
    ctl_t  a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
      end
    end
  end

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, want);
    end
  endtask

`ifdef CTRL_PERF_EN
  task automatic chk32(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, want);
    end
  endtask
`endif

  // Called just after a rising edge; drives one cycle's inputs and queues its expected word.
  task automatic cyc(input ctl_t e, input string n, input logic mr, input logic z,
                     input logic [5:0] op);
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.opcode    = op;
    exp_q.push_back(e);
    name_q.push_back(n);
`ifdef CTRL_PERF_EN
    if (e.st != TRAP) model_cycles++;
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero      = rbit();
    bus.opcode    = rop();
    #1;
    chk("reset_state", 8'(bus.state_dbg), 8'(FETCH));
    chk("reset_enables", 8'({bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
                             bus.pc_en}), 8'h00);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_held", 8'({bus.state_dbg, bus.illegal, bus.ir_write, bus.pc_en, bus.mem_read}),
        8'h00);
    chk("reset_alu_op", 8'(bus.alu_op), 8'h00);
    reset_n = 1'b1;
`ifdef CTRL_PERF_EN
    model_cycles = 0;
    model_instrs = 0;
`endif
  endtask

  task automatic issue(input logic [5:0] op, input int fw, input int mw, input logic zb);
    int c;
    c = cls(op);
    for (int i = 0; i < fw; i++)
      cyc(mk(FETCH, 4'b0000, N, 2'b01, N, Y, N, N, N, N, N, 2'b00, N, N), "fetch_wait",
          N, rbit(), rop());
    cyc(mk(FETCH, 4'b0000, N, 2'b01, N, Y, N, Y, N, N, N, 2'b00, Y, N), "fetch", Y, rbit(), op);
    cyc(mk(DECODE, 4'b0000, N, 2'b11, N, N, N, N, N, N, N, 2'b00, N, N), "decode",
        rbit(), rbit(), rop());
    case (c)
      C_R: begin
        cyc(mk(EXEC_R, 4'b1111, Y, 2'b00, N, N, N, N, N, N, N, 2'b00, N, N), "exec_r",
            rbit(), rbit(), rop());
        cyc(mk(ALU_WB, 4'b0000, N, 2'b00, N, N, N, N, Y, Y, N, 2'b00, N, N), "alu_wb_r",
            rbit(), rbit(), rop());
      end
      C_I: begin
        cyc(mk(EXEC_I, ialu(op), Y, 2'b10, N, N, N, N, N, N, N, 2'b00, N, N), "exec_i",
            rbit(), rbit(), rop());
        cyc(mk(ALU_WB, 4'b0000, N, 2'b00, N, N, N, N, Y, N, N, 2'b00, N, N), "alu_wb_i",
            rbit(), rbit(), rop());
      end
      C_LW, C_SW: begin
        cyc(mk(MEM_ADDR, 4'b0000, Y, 2'b10, N, N, N, N, N, N, N, 2'b00, N, N), "mem_addr",
            rbit(), rbit(), rop());
        for (int i = 0; i <= mw; i++)
          cyc(mk((c == C_LW) ? MEM_RD : MEM_WR, 4'b0000, N, 2'b00, Y, (c == C_LW), (c == C_SW),
                 N, N, N, N, 2'b00, N, N), (c == C_LW) ? "mem_rd" : "mem_wr",
              (i == mw), rbit(), rop());
        if (c == C_LW)
          cyc(mk(MEM_WB, 4'b0000, N, 2'b00, N, N, N, N, Y, N, Y, 2'b00, N, N), "mem_wb",
              rbit(), rbit(), rop());
      end
      C_BEQ:
        cyc(mk(BRANCH, 4'b0001, Y, 2'b00, N, N, N, N, N, N, N, 2'b01, zb, N), "beq",
            rbit(), zb, rop());
      C_BNE:
        cyc(mk(BRANCH, 4'b0010, Y, 2'b00, N, N, N, N, N, N, N, 2'b01, ~zb, N), "bne",
            rbit(), zb, rop());
      C_J:
        cyc(mk(JUMP, 4'b0000, N, 2'b00, N, N, N, N, N, N, N, 2'b10, Y, N), "jump",
            rbit(), rbit(), rop());
      default: begin
`ifdef CTRL_PERF_EN
        chk32("perf_cycles_at_trap", perf_cycles, 32'(model_cycles));
        chk32("perf_instrs_at_trap", perf_instrs, 32'(model_instrs));
`endif
        for (int i = 0; i < 10; i++)
          cyc(mk(TRAP, 4'b0000, N, 2'b00, N, N, N, N, N, N, N, 2'b00, N, Y), "trap",
              rbit(), rbit(), rop());
`ifdef CTRL_PERF_EN
        chk32("perf_cycles_frozen", perf_cycles, 32'(model_cycles));
`endif
        do_reset();
      end
    endcase
`ifdef CTRL_PERF_EN
    if (c != C_ILL) model_instrs++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000,
              6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = 6'b000000;
    @(posedge clock);
    #1;
    do_reset();

    issue(6'b000000, 0, 0, N);
    issue(6'b100011, 0, 2, N);
    issue(6'b101011, 1, 1, N);
    issue(6'b000100, 0, 0, Y);
    issue(6'b000101, 0, 0, Y);
    issue(6'b000100, 2, 0, N);
    issue(6'b000101, 0, 0, N);
    issue(6'b001101, 0, 0, N);
    issue(6'b001111, 1, 0, N);
    issue(6'b000010, 0, 0, N);

    // Abort an add in EXEC_R; reset must drop everything before the next edge.
    cyc(mk(FETCH, 4'b0000, N, 2'b01, N, Y, N, Y, N, N, N, 2'b00, Y, N), "abort_fetch",
        Y, rbit(), 6'b000000);
    cyc(mk(DECODE, 4'b0000, N, 2'b11, N, N, N, N, N, N, N, 2'b00, N, N), "abort_decode",
        rbit(), rbit(), rop());
    chk("abort_in_exec_r", 8'(bus.state_dbg), 8'(EXEC_R));
    chk("abort_exec_r_aluop", 8'(bus.alu_op), 8'h0F);
    do_reset();
    issue(6'b000000, 0, 0, N);

    for (int k = 0; k < 40; k++) begin
      op = legal[$urandom_range(0, 12)];
      issue(op, $urandom_range(0, 2), $urandom_range(0, 2), rbit());
    end

    issue(6'b111111, 0, 0, N);
    for (int k = 0; k < 10; k++) begin
      op = legal[$urandom_range(0, 12)];
      issue(op, $urandom_range(0, 2), $urandom_range(0, 2), rbit());
    end
    do op = rop(); while (cls(op) != C_ILL);
    issue(op, 1, 0, N);
    issue(6'b000000, 0, 0, N);

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
